// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and default link constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int UART_CLKS_PER_BIT = 434;
    localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/NBitRegister.sv
// Loadable N-bit register with asynchronous active-low clear to a preload value.
module NBitRegister #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] PRELOAD = '0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q <= PRELOAD;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: latches a word on handshake, then shifts a
// start/data/stop frame onto tx LSB first, paced by a baud counter.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    uart_tx_state_t       state, state_nxt;
    logic [BAUD_W-1:0]    baud_cnt, baud_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_nxt;
    logic                 tx_nxt, ready_nxt;
    logic                 accept, bit_done;
    logic [DATA_BITS-1:0] hold;

    assign accept   = tx_valid && tx_ready;
    assign bit_done = (baud_cnt == BAUD_LAST);
    assign busy     = !tx_ready;

    NBitRegister #(
        .WIDTH   (DATA_BITS),
        .PRELOAD ({DATA_BITS{1'b0}})
    ) u_hold (
        .clk     (clk),
        .clear_n (clear_n),
        .ld      (accept),
        .d       (tx_data),
        .q       (hold)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            tx       <= tx_nxt;
            tx_ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = START;
            START:   if (bit_done) state_nxt = DATA;
            DATA:    if (bit_done && (bit_cnt == DATA_LAST)) state_nxt = STOP;
            STOP:    if (bit_done && (bit_cnt == STOP_LAST)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // tx and tx_ready are registered, so their next values are computed here
    // one edge ahead; the data bit is picked from the holding register by bit_nxt.
    always_comb begin
        baud_nxt  = bit_done ? '0 : baud_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        tx_nxt    = tx;
        ready_nxt = tx_ready;
        case (state)
            IDLE: begin
                baud_nxt  = '0;
                bit_nxt   = '0;
                tx_nxt    = 1'b1;
                ready_nxt = 1'b1;
                if (accept) begin
                    tx_nxt    = 1'b0;
                    ready_nxt = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_nxt = '0;
                    tx_nxt  = hold[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt = '0;
                        tx_nxt  = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (BIT_W'(i) == bit_nxt) tx_nxt = hold[i];
                        end
                    end
                end
            end
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_done) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_nxt   = '0;
                        ready_nxt = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                baud_nxt  = '0;
                bit_nxt   = '0;
                tx_nxt    = 1'b1;
                ready_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: two instances (C=4,S=1 and C=2,S=2),
// expected frames computed from the byte and frame geometry.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       valid0, valid1;
    logic [7:0] data0, data1;
    logic       tx0, tx1, ready0, ready1, busy0, busy1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         starts0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
        .clk(clk), .clear_n(clear_n), .tx_data(data0), .tx_valid(valid0),
        .tx_ready(ready0), .tx(tx0), .busy(busy0)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(2), .DATA_BITS(8), .STOP_BITS(2)) dut1 (
        .clk(clk), .clear_n(clear_n), .tx_data(data1), .tx_valid(valid1),
        .tx_ready(ready1), .tx(tx1), .busy(busy1)
    );

    function automatic logic get_tx(input int idx);
        return (idx == 0) ? tx0 : tx1;
    endfunction

    function automatic logic get_rdy(input int idx);
        return (idx == 0) ? ready0 : ready1;
    endfunction

    function automatic logic get_busy(input int idx);
        return (idx == 0) ? busy0 : busy1;
    endfunction

    // Line level t cycles into a frame: slot 0 start, slots 1..8 data LSB first, then stop.
    function automatic logic exp_level(input logic [7:0] d, input int t, input int c);
        int slot;
        slot = t / c;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        return 1'b1;
    endfunction

    task automatic drive(input int idx, input logic v, input logic [7:0] d);
        if (idx == 0) begin valid0 = v; data0 = d; end
        else          begin valid1 = v; data1 = d; end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic send(input int idx, input logic [7:0] d, input bit keep);
        int n;
        n = 0;
        drive(idx, 1'b1, d);
        while (!get_rdy(idx) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!get_rdy(idx)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout idx=%0d got ready=0 want ready=1", idx);
            drive(idx, 1'b0, d);
            return;
        end
        if (idx == 0) q0.push_back(d);
        else          q1.push_back(d);
        @(negedge clk);
        if (!keep) drive(idx, 1'b0, d);
    endtask

    task automatic wait_idle(input int idx);
        int n;
        int hi;
        n  = 0;
        hi = 0;
        while (hi < 2 && n < 1000) begin
            @(negedge clk);
            n++;
            if (get_rdy(idx)) hi++;
            else hi = 0;
        end
        if (hi < 2) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout idx=%0d got ready=0 want ready=1", idx);
        end
    endtask

    task automatic monitor(input int idx);
        int         c;
        int         frame;
        int         t;
        int         bad;
        bit         in_frame;
        bit         end_chk;
        logic [7:0] e;
        c        = (idx == 0) ? 4 : 2;
        frame    = (idx == 0) ? (1 + 8 + 1) * 4 : (1 + 8 + 2) * 2;
        in_frame = 1'b0;
        end_chk  = 1'b0;
        t        = 0;
        bad      = 0;
        e        = 8'h00;
        forever begin
            @(negedge clk);
            if (!clear_n) begin
                in_frame = 1'b0;
                end_chk  = 1'b0;
                continue;
            end
            checks++;
            if (get_busy(idx) !== !get_rdy(idx)) begin
                errors++;
                $display("FAIL busy idx=%0d got=%b want=%b", idx, get_busy(idx), !get_rdy(idx));
            end
            if (end_chk) begin
                end_chk = 1'b0;
                checks++;
                if (get_rdy(idx) !== 1'b1 || get_tx(idx) !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_end idx=%0d got ready=%b tx=%b want ready=1 tx=1",
                             idx, get_rdy(idx), get_tx(idx));
                end
            end else if (!in_frame) begin
                if (!get_rdy(idx)) begin
                    in_frame = 1'b1;
                    t        = 0;
                    bad      = 0;
                    if (idx == 0 && q0.size() > 0) e = q0.pop_front();
                    else if (idx == 1 && q1.size() > 0) e = q1.pop_front();
                    else begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame idx=%0d got frame want none", idx);
                    end
                    if (idx == 0) starts0.push_back(cyc);
                end else begin
                    checks++;
                    if (get_tx(idx) !== 1'b1) begin
                        errors++;
                        $display("FAIL idle_tx idx=%0d got=%b want=1", idx, get_tx(idx));
                    end
                end
            end
            if (in_frame) begin
                if (get_tx(idx) !== exp_level(e, t, c) || get_rdy(idx) !== 1'b0) bad++;
                t++;
                if (t == frame) begin
                    checks++;
                    if (bad != 0) begin
                        errors++;
                        $display("FAIL frame idx=%0d data=%h got %0d bad cycles want 0", idx, e, bad);
                    end
                    in_frame = 1'b0;
                    end_chk  = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
    end

    initial begin
        int         idx;
        int         nb;
        logic [7:0] rb;
        clear_n = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_tx0", tx0, 1);
        check("reset_ready0", ready0, 1);
        check("reset_busy0", busy0, 0);
        check("reset_tx1", tx1, 1);
        check("reset_ready1", ready1, 1);
        #2 clear_n = 1'b1;
        @(negedge clk);

        send(0, 8'hA5, 1'b0);
        wait_idle(0);

        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b0);
        wait_idle(0);
        if (starts0.size() >= 2)
            check("b2b_spacing", starts0[starts0.size()-1] - starts0[starts0.size()-2], 41);
        else
            check("b2b_frames", starts0.size(), 2);

        send(0, 8'h55, 1'b0);
        drive(0, 1'b0, 8'hAA);
        wait_idle(0);

        send(1, 8'h01, 1'b0);
        wait_idle(1);

        // Abort mid data bit 3 of 0x3C; outputs must recover without a clock edge.
        send(0, 8'h3C, 1'b0);
        repeat (17) @(negedge clk);
        check("midframe_ready", ready0, 0);
        #1 clear_n = 1'b0;
        #1;
        check("async_tx", tx0, 1);
        check("async_ready", ready0, 1);
        check("async_busy", busy0, 0);
        @(negedge clk);
        #2 clear_n = 1'b1;
        @(negedge clk);
        send(0, 8'h81, 1'b0);
        wait_idle(0);

        repeat (100) @(negedge clk);
        check("long_idle_tx", tx0, 1);
        check("long_idle_ready", ready0, 1);

        for (int k = 0; k < 12; k++) begin
            idx = int'($urandom_range(0, 1));
            nb  = int'($urandom_range(1, 3));
            for (int j = 0; j < nb; j++) begin
                rb = 8'($urandom);
                send(idx, rb, j < nb - 1);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_idle(0);
        wait_idle(1);
        check("queues_drained", q0.size() + q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
